// File: rtl/neo_link_pkg.sv
// Shared definitions for both ends of the NEO board-to-board serial link.
// This package holds the frame constants, the default link parameters and the receiver state type.
package neo_link_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_CLKS_PER_BIT = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic {
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    localparam parity_t PARITY_SENSE = PAR_EVEN;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for one asynchronous input bit.
// Ports: clock, reset (sync, active high), d (async in), q (synchronized out).
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/neo_link_receiver.sv
// Receive end of the NEO serial link: start, LSB-first data, even parity, stop.
// Ports: clock, reset, rx_in, rx_enable -> message_data_out, new_message_received,
//        parity_error, framing_error (one-cycle pulses), busy (not IDLE).
module neo_link_receiver
    import neo_link_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  rx_enable,
    output logic [DATA_WIDTH-1:0] message_data_out,
    output logic                  new_message_received,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

    logic                  rx_sync;
    rx_state_t             state, state_n;
    logic [CW-1:0]         clk_cnt, cnt_n;
    logic [IW-1:0]         bit_idx, idx_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [DATA_WIDTH-1:0] msg_n;
    logic                  par_ok, par_ok_n;
    logic                  nm_n, pe_n, fe_n;
    logic                  bit_tick;

    bit_synchronizer #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_sync)
    );

    assign bit_tick = (clk_cnt == BIT_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            clk_cnt              <= '0;
            bit_idx              <= '0;
            shift_reg            <= '0;
            par_ok               <= 1'b0;
            message_data_out     <= '0;
            new_message_received <= 1'b0;
            parity_error         <= 1'b0;
            framing_error        <= 1'b0;
        end else begin
            state                <= state_n;
            clk_cnt              <= cnt_n;
            bit_idx              <= idx_n;
            shift_reg            <= shift_n;
            par_ok               <= par_ok_n;
            message_data_out     <= msg_n;
            new_message_received <= nm_n;
            parity_error         <= pe_n;
            framing_error        <= fe_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = clk_cnt + 1'b1;
        idx_n    = bit_idx;
        shift_n  = shift_reg;
        par_ok_n = par_ok;
        msg_n    = message_data_out;
        nm_n     = 1'b0;
        pe_n     = 1'b0;
        fe_n     = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_enable && rx_sync == START_BIT) begin
                    state_n = START;
                end
            end
            // Re-check the line half a bit in; a short glitch is dropped silently.
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = (rx_sync == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_n = PARITY;
                    end else begin
                        idx_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_n    = '0;
                    par_ok_n = ((^shift_reg) ^ rx_sync)
                               == (PARITY_SENSE == PAR_ODD);
                    state_n  = STOP;
                end
            end
            // Leaving at mid-stop lets an immediately following start bit be seen.
            STOP: begin
                if (bit_tick) begin
                    cnt_n = '0;
                    if (rx_sync != STOP_BIT) begin
                        fe_n    = 1'b1;
                        state_n = WAIT_IDLE;
                    end else if (par_ok) begin
                        msg_n   = shift_reg;
                        nm_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        pe_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            // A line stuck low must not look like a stream of start bits.
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_sync == STOP_BIT) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neo_link_receiver.sv
// Self-checking bench for neo_link_receiver: directed and random frames
// compared against a frame-level model of the link.
module tb_neo_link_receiver;

    localparam int DW  = 32;
    localparam int CPB = 16;
    localparam int FRAME_BITS = DW + 3;
    // Edge (relative to t0) after which a result pulse is high.
    localparam int LAT = 2 + CPB / 2 + (DW + 2) * CPB;

    localparam int K_GOOD = 0;
    localparam int K_PAR  = 1;
    localparam int K_STOP = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx_in = 1'b1;
    logic          rx_enable = 1'b1;
    logic [DW-1:0] message_data_out;
    logic          new_message_received;
    logic          parity_error;
    logic          framing_error;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nm_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int nm_cyc = 0, pe_cyc = 0, fe_cyc = 0;

    logic [DW-1:0] model_msg = '0;

    neo_link_receiver #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .rx_in                (rx_in),
        .rx_enable            (rx_enable),
        .message_data_out     (message_data_out),
        .new_message_received (new_message_received),
        .parity_error         (parity_error),
        .framing_error        (framing_error),
        .busy                 (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (new_message_received) begin
            nm_cnt++;
            nm_cyc = cyc;
        end
        if (parity_error) begin
            pe_cnt++;
            pe_cyc = cyc;
        end
        if (framing_error) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one frame; must be entered just after a rising edge.
    task automatic send_frame(input logic [DW-1:0] data,
                              input bit bad_par,
                              input bit bad_stop,
                              output int t0);
        logic [FRAME_BITS-1:0] bits;
        logic par;
        par  = (($countones(data) % 2) == 1) ^ bad_par;
        bits = {~bad_stop, par, data, 1'b0};
        t0   = cyc + 1;
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
    endtask

    // Frame-level outcome rule: bad stop wins, then parity, else good.
    function automatic int outcome(input logic [DW-1:0] data,
                                   input bit bad_par,
                                   input bit bad_stop);
        int ones;
        if (bad_stop) return K_STOP;
        ones = $countones(data) + (($countones(data) % 2) ^ bad_par);
        return (ones % 2 == 0) ? K_GOOD : K_PAR;
    endfunction

    task automatic run_frame(input string tag,
                             input logic [DW-1:0] data,
                             input bit bad_par,
                             input bit bad_stop);
        int t0, k, nm0, pe0, fe0;
        nm0 = nm_cnt;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        k = outcome(data, bad_par, bad_stop);
        send_frame(data, bad_par, bad_stop, t0);
        if (k == K_GOOD) model_msg = data;
        chk({tag, ".nm"}, nm_cnt - nm0, (k == K_GOOD) ? 1 : 0);
        chk({tag, ".pe"}, pe_cnt - pe0, (k == K_PAR) ? 1 : 0);
        chk({tag, ".fe"}, fe_cnt - fe0, (k == K_STOP) ? 1 : 0);
        if (k == K_GOOD) chk({tag, ".lat"}, nm_cyc - t0, LAT);
        if (k == K_PAR)  chk({tag, ".lat"}, pe_cyc - t0, LAT);
        if (k == K_STOP) chk({tag, ".lat"}, fe_cyc - t0, LAT);
        chk({tag, ".msg"}, message_data_out, model_msg);
    endtask

    initial begin
        int t0a, t0b, c0, nm0, pe0, fe0, lowcnt, first_cyc, k;
        logic [DW-1:0] d;

        step(4);
        reset = 1'b0;

        step(100);
        chk("rst.busy", busy, 0);
        chk("rst.msg", message_data_out, 0);
        chk("rst.pulses", nm_cnt + pe_cnt + fe_cnt, 0);

        run_frame("good", 32'hA5C3_0F81, 1'b0, 1'b0);
        step(10);
        run_frame("par", 32'h1234_5678, 1'b1, 1'b0);
        step(10);

        // Bad stop bit, then line stuck low.
        run_frame("stop", 32'h0F0F_1234, 1'b0, 1'b1);
        lowcnt = 0;
        c0 = nm_cnt + pe_cnt + fe_cnt;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (!busy) lowcnt++;
        end
        chk("stuck.busy_low", lowcnt, 0);
        chk("stuck.pulses", nm_cnt + pe_cnt + fe_cnt - c0, 0);
        rx_in = 1'b1;
        step(4);
        chk("stuck.release", busy, 0);
        step(50);
        chk("stuck.retrig", nm_cnt + pe_cnt + fe_cnt - c0, 0);

        // Five-cycle glitch on an idle line.
        c0 = nm_cnt + pe_cnt + fe_cnt;
        rx_in = 1'b0;
        step(5);
        rx_in = 1'b1;
        step(CPB / 2 + 3 - 5 + 1);
        chk("glitch.busy", busy, 0);
        step(40);
        chk("glitch.pulses", nm_cnt + pe_cnt + fe_cnt - c0, 0);
        chk("glitch.msg", message_data_out, model_msg);

        // Back-to-back: the stop bit is a full bit, so pulses are one frame apart.
        run_frame("b2b1", 32'h0000_0001, 1'b0, 1'b0);
        first_cyc = nm_cyc;
        run_frame("b2b2", 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("b2b.gap", nm_cyc - first_cyc, FRAME_BITS * CPB);
        step(20);

        // Back-to-back with reset in the middle of the second frame.
        run_frame("rb2b1", 32'h0000_0001, 1'b0, 1'b0);
        nm0 = nm_cnt;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        fork
            send_frame(32'hFFFF_FFFE, 1'b0, 1'b0, t0b);
            begin
                step(300);
                reset = 1'b1;
                step(2);
                reset = 1'b0;
            end
        join
        model_msg = '0;
        step(20);
        chk("rst_mid.nm", nm_cnt - nm0, 0);
        chk("rst_mid.err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);
        chk("rst_mid.msg", message_data_out, model_msg);
        chk("rst_mid.busy", busy, 0);

        // Enable dropped mid-frame does not disturb the frame.
        nm0 = nm_cnt;
        d = $urandom;
        fork
            send_frame(d, 1'b0, 1'b0, t0a);
            begin
                step(100);
                rx_enable = 1'b0;
            end
        join
        model_msg = d;
        chk("en_mid.nm", nm_cnt - nm0, 1);
        chk("en_mid.msg", message_data_out, model_msg);

        // Enable low for a whole frame: nothing is received.
        c0 = nm_cnt + pe_cnt + fe_cnt;
        lowcnt = 0;
        fork
            send_frame($urandom, 1'b0, 1'b0, t0a);
            for (int i = 0; i < FRAME_BITS * CPB - 2; i++) begin
                step(1);
                if (busy) lowcnt++;
            end
        join
        rx_enable = 1'b1;
        step(10);
        chk("en_off.pulses", nm_cnt + pe_cnt + fe_cnt - c0, 0);
        chk("en_off.busy", lowcnt, 0);
        chk("en_off.msg", message_data_out, model_msg);

        // Random frames with random gaps, including back-to-back.
        for (int n = 0; n < 12; n++) begin
            d = $urandom;
            k = $urandom_range(0, 9);
            run_frame("rnd", d, (k >= 6 && k < 8), (k >= 8));
            if (k >= 8) begin
                step($urandom_range(0, 60));
                rx_in = 1'b1;
                step($urandom_range(3, 20));
            end else begin
                step($urandom_range(0, 30));
            end
        end

        step(10);
        chk("end.busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
